// File: rtl/da_slicer.sv
// da_slicer: front-end sequencer for a distributed-arithmetic FIR core.
// Holds a 64-tap sample delay line (8 banks x 8 taps). For every accepted
// sample it walks the sample bits MSB first. Each bit-slice drives the eight
// bank addresses to the DA core and waits for its slice-done pulse. After
// the last slice it captures the core's accumulator as the filter output.
module da_slicer #(
  parameter int SAMPLE_W = 16,
  parameter int ACC_W    = 39,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                flush,
  input  logic                coef_busy,
  output logic [7:0]          A7,
  output logic [7:0]          A6,
  output logic [7:0]          A5,
  output logic [7:0]          A4,
  output logic [7:0]          A3,
  output logic [7:0]          A2,
  output logic [7:0]          A1,
  output logic [7:0]          A0,
  output logic                da_reset,
  output logic                da_start,
  output logic                da_valid_in,
  input  logic                da_done,
  input  logic [ACC_W-1:0]    acc_in,
  output logic [ACC_W-1:0]    y_data,
  output logic                y_valid,
  output logic                err
);

  localparam int NTAPS = 64;
  localparam int BIT_W = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(SAMPLE_W - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_CAPTURE
  } state_t;

  state_t             state_q, state_d;
  logic [BIT_W-1:0]   bit_q;
  logic [CNT_W-1:0]   wcnt_q;
  logic [SAMPLE_W-1:0] taps_q [NTAPS];
  logic [7:0]         bank [8];

  logic accept;
  logic clear_taps;
  logic timeout;

  // Next-state and handshake/strobe decode for the slice sequencer.
  always_comb begin
    state_d     = state_q;
    s_ready     = 1'b0;
    da_reset    = 1'b0;
    da_start    = 1'b0;
    da_valid_in = 1'b0;
    accept      = 1'b0;
    clear_taps  = 1'b0;
    timeout     = 1'b0;
    if (resetn) begin
      case (state_q)
        S_IDLE: begin
          // A flush takes the whole cycle: no acceptance alongside it.
          if (flush) begin
            clear_taps = 1'b1;
          end else begin
            s_ready = ~coef_busy;
            if (s_valid && !coef_busy) begin
              accept  = 1'b1;
              state_d = S_CLR;
            end
          end
        end
        S_CLR: begin
          da_reset = 1'b1;
          state_d  = S_ISSUE;
        end
        S_ISSUE: begin
          da_valid_in = 1'b1;
          da_start    = (bit_q == BIT_MSB);
          state_d     = S_WAIT;
        end
        S_WAIT: begin
          if (da_done) begin
            state_d = (bit_q == '0) ? S_DRAIN : S_ISSUE;
          end else if (wcnt_q == CNT_LAST) begin
            timeout = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_DRAIN:   state_d = S_CAPTURE;
        S_CAPTURE: state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Bank addresses: bit b of taps 8k..8k+7, shown only while a slice is live.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      bank[k] = '0;
      if (resetn && (state_q == S_ISSUE || state_q == S_WAIT)) begin
        for (int j = 0; j < 8; j++) begin
          bank[k][j] = taps_q[8*k+j][bit_q];
        end
      end
    end
  end

  assign A0 = bank[0];
  assign A1 = bank[1];
  assign A2 = bank[2];
  assign A3 = bank[3];
  assign A4 = bank[4];
  assign A5 = bank[5];
  assign A6 = bank[6];
  assign A7 = bank[7];

  // Control state: FSM, slice index, wait counter, output strobe, sticky error.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      bit_q   <= BIT_MSB;
      wcnt_q  <= '0;
      y_valid <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      y_valid <= (state_q == S_CAPTURE);
      if (accept) begin
        bit_q <= BIT_MSB;
      end else if (state_q == S_WAIT && da_done && bit_q != '0) begin
        bit_q <= bit_q - BIT_W'(1);
      end
      if (state_q == S_ISSUE) begin
        wcnt_q <= '0;
      end else if (state_q == S_WAIT) begin
        wcnt_q <= wcnt_q + CNT_W'(1);
      end
      if (timeout) begin
        err <= 1'b1;
      end
    end
  end

  // Delay line and result register; both restart from zero after reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NTAPS; i++) begin
        taps_q[i] <= '0;
      end
      y_data <= '0;
    end else begin
      if (clear_taps) begin
        for (int i = 0; i < NTAPS; i++) begin
          taps_q[i] <= '0;
        end
      end else if (accept) begin
        for (int i = NTAPS - 1; i > 0; i--) begin
          taps_q[i] <= taps_q[i-1];
        end
        taps_q[0] <= s_data;
      end
      if (state_q == S_CAPTURE) begin
        y_data <= acc_in;
      end
    end
  end

endmodule

// File: tb/tb_da_slicer.sv
// Testbench for da_slicer with a behavioural DA core (done 3 cycles after each
// slice strobe, accumulator shift-add the cycle after done) and a reference
// delay-line model feeding an expected-result queue.
module tb_da_slicer;

  localparam int SW = 16;
  localparam int AW = 39;
  localparam int TO = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn, s_valid, s_ready, flush, coef_busy;
  logic [SW-1:0] s_data;
  logic [7:0]    A7, A6, A5, A4, A3, A2, A1, A0;
  logic          da_reset, da_start, da_valid_in, da_done;
  logic [AW-1:0] acc_in, y_data;
  logic          y_valid, err;

  da_slicer #(.SAMPLE_W(SW), .ACC_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .flush(flush), .coef_busy(coef_busy),
    .A7(A7), .A6(A6), .A5(A5), .A4(A4), .A3(A3), .A2(A2), .A1(A1), .A0(A0),
    .da_reset(da_reset), .da_start(da_start), .da_valid_in(da_valid_in),
    .da_done(da_done), .acc_in(acc_in), .y_data(y_data), .y_valid(y_valid),
    .err(err)
  );

  int tests = 0;
  int fails = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction

  // Reference model state
  logic [SW-1:0] mtaps [64];
  bit   hone = 1'b0;
  bit   withhold = 1'b0;
  logic stray = 1'b0;

  function automatic logic [63:0] hval(input int i);
    return hone ? 64'd1 : 64'(i + 1);
  endfunction

  function automatic logic [63:0] model_y();
    logic [63:0] s = 64'd0;
    for (int i = 0; i < 64; i++) s = s + hval(i) * 64'(mtaps[i]);
    return s;
  endfunction

  function automatic void mshift(input logic [SW-1:0] d);
    for (int i = 63; i > 0; i--) mtaps[i] = mtaps[i-1];
    mtaps[0] = d;
  endfunction

  function automatic void mclear();
    for (int i = 0; i < 64; i++) mtaps[i] = '0;
  endfunction

  // Behavioural DA core
  logic [7:0]    abank [8];
  logic [AW-1:0] acc_m;
  logic [1:0]    pend;
  logic          model_done;
  assign abank[0] = A0; assign abank[1] = A1; assign abank[2] = A2; assign abank[3] = A3;
  assign abank[4] = A4; assign abank[5] = A5; assign abank[6] = A6; assign abank[7] = A7;
  assign acc_in  = acc_m;
  assign da_done = model_done | stray;

  function automatic logic [AW-1:0] slice_sum();
    logic [63:0] s = 64'd0;
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 8; j++)
        if (abank[k][j]) s = s + hval(8*k + j);
    return s[AW-1:0];
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      pend <= 2'd0; model_done <= 1'b0; acc_m <= '0;
    end else begin
      model_done <= 1'b0;
      if (da_reset) acc_m <= '0;
      if (model_done) acc_m <= (acc_m << 1) + slice_sum();
      if (da_valid_in) pend <= 2'd1;
      else if (pend == 2'd1) pend <= 2'd2;
      else if (pend == 2'd2) begin
        pend <= 2'd0;
        if (!withhold) model_done <= 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  logic [AW-1:0] expq [$];
  int cyc = 0;
  int nyv = 0, nvalid = 0, nstart = 0, nreset = 0, yv_cyc = 0, acc_cyc = 0;
  bit order_bad = 1'b0;
  logic [63:0] first_a = 64'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resetn) begin
      if (da_reset) nreset++;
      if (da_start && !da_valid_in) order_bad = 1'b1;
      if (da_valid_in) begin
        if (nvalid == 0) begin
          first_a = {A7, A6, A5, A4, A3, A2, A1, A0};
          if (!da_start || nreset != 1) order_bad = 1'b1;
        end else if (da_start) order_bad = 1'b1;
        nvalid++;
      end
      if (y_valid) begin
        nyv++;
        yv_cyc = cyc;
        chk("y_valid_expected", 64'(expq.size() > 0), 64'd1);
        if (expq.size() > 0) chk("y_data", 64'(y_data), 64'(expq.pop_front()));
      end
    end
  end

  task automatic wait_idle(output int at);
    int n = 0;
    @(negedge clk);
    while (!s_ready && n < 2000) begin @(negedge clk); n++; end
    #1;
    at = cyc;
    if (!s_ready) chk("idle_timeout", 64'(s_ready), 64'd1);
  endtask

  task automatic send(input logic [SW-1:0] d, input bit push, input bit use_model,
                      input logic [AW-1:0] e, input bit wait_done);
    int n = 0;
    int at;
    logic [63:0] m;
    while (!s_ready && n < 2000) begin @(negedge clk); n++; end
    if (!s_ready) begin
      chk("accept_timeout", 64'(s_ready), 64'd1);
      return;
    end
    s_data = d; s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    mshift(d);
    m = model_y();
    if (push) expq.push_back(use_model ? m[AW-1:0] : e);
    nvalid = 0; nstart = 0; nreset = 0; nyv = 0; order_bad = 1'b0; acc_cyc = cyc;
    if (wait_done) wait_idle(at);
  endtask

  typedef struct {
    logic [SW-1:0] d;
    logic [AW-1:0] exp;
  } vec_t;
  vec_t vec [65];

  initial begin : main
    int at;
    // table: impulse walking through the delay line, h_i = i+1
    vec[0].d = 16'd1; vec[0].exp = 39'd1;
    for (int m = 1; m < 65; m++) begin
      vec[m].d   = 16'd0;
      vec[m].exp = (m <= 63) ? AW'(m + 1) : '0;
    end

    resetn = 1'b0; s_valid = 1'b0; s_data = '0; flush = 1'b0; coef_busy = 1'b0;
    mclear();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_addr", {A7, A6, A5, A4, A3, A2, A1, A0}, 64'd0);
    chk("rst_da", 64'({da_reset, da_start, da_valid_in}), 64'd0);
    chk("rst_y", 64'({y_valid, err, y_data}), 64'd0);
    resetn = 1'b1;
    @(negedge clk); #1;
    chk("idle_s_ready", 64'(s_ready), 64'd1);

    // coef_busy blocks acceptance
    coef_busy = 1'b1; s_data = 16'h1234; s_valid = 1'b1;
    #1;
    chk("busy_s_ready", 64'(s_ready), 64'd0);
    repeat (5) @(negedge clk);
    chk("busy_no_start", 64'(nreset + nvalid), 64'd0);
    s_valid = 1'b0; coef_busy = 1'b0;
    @(negedge clk);

    // table-driven impulse response
    for (int i = 0; i < 65; i++) begin
      send(vec[i].d, 1'b1, 1'b0, vec[i].exp, 1'b1);
      if (i == 0) begin
        chk("slices", 64'(nvalid), 64'd16);
        chk("da_reset_cnt", 64'(nreset), 64'd1);
        chk("start_order", 64'(order_bad), 64'd0);
        chk("latency", 64'(yv_cyc - acc_cyc), 64'd67);
        chk("msb_addr_impulse", first_a, 64'd0);
        chk("y_count", 64'(nyv), 64'd1);
      end
    end

    // stray da_done in IDLE
    nvalid = 0; nreset = 0; nyv = 0;
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    @(negedge clk); #1;
    chk("stray_idle", 64'(s_ready), 64'd1);
    chk("stray_no_act", 64'(nvalid + nreset + nyv), 64'd0);

    // all taps 0xFFFF, h_i = 1
    hone = 1'b1;
    for (int i = 0; i < 64; i++)
      send(16'hFFFF, 1'b1, (i != 63), 39'd4194240, 1'b1);
    chk("msb_addr_full", first_a, 64'hFFFF_FFFF_FFFF_FFFF);

    // flush in IDLE
    flush = 1'b1;
    #1;
    chk("flush_s_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    mclear();
    hone = 1'b0;
    send(16'd0, 1'b1, 1'b0, 39'd0, 1'b1);

    // flush during WAIT is ignored
    send(16'd7, 1'b1, 1'b0, 39'd7, 1'b0);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    repeat (2) @(negedge clk);
    flush = 1'b0;
    wait_idle(at);
    send(16'd0, 1'b1, 1'b0, 39'd14, 1'b1);

    // timeout abort, then normal operation with err held
    withhold = 1'b1;
    send(16'd3, 1'b0, 1'b0, '0, 1'b1);
    chk("timeout_err", 64'(err), 64'd1);
    chk("timeout_no_y", 64'(nyv), 64'd0);
    chk("timeout_cycles", 64'(cyc - acc_cyc), 64'd257);
    withhold = 1'b0;
    send(16'd0, 1'b1, 1'b0, 39'd34, 1'b1);
    chk("err_sticky", 64'(err), 64'd1);

    // reset during WAIT
    send(16'd5, 1'b0, 1'b0, '0, 1'b0);
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk); #1;
    chk("midrst_addr", {A7, A6, A5, A4, A3, A2, A1, A0}, 64'd0);
    chk("midrst_da", 64'({da_reset, da_start, da_valid_in, s_ready}), 64'd0);
    chk("midrst_y", 64'({y_valid, err, y_data}), 64'd0);
    resetn = 1'b1;
    mclear();
    @(negedge clk);
    send(16'd1, 1'b1, 1'b0, 39'd1, 1'b1);

    chk("queue_empty", 64'(expq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d failed so far", fails);
    $fatal(1, "watchdog");
  end

endmodule
